// File: rtl/food_placer_if.sv
// Bundle between the food placer, the game controller (rnd/request) and the snake body store.
// The game side is the master; the placer itself uses the slave modport.
interface food_placer_if;
    logic [6:0] rnd;
    logic       food_request;
    logic       occ_hit;
    logic       occ_query;
    logic [6:0] occ_addr;
    logic [3:0] food_x;
    logic [2:0] food_y;
    logic       food_valid;
    logic       busy;
    logic       grid_full;

    modport master (
        output rnd, food_request, occ_hit,
        input  occ_query, occ_addr, food_x, food_y, food_valid, busy, grid_full
    );

    modport slave (
        input  rnd, food_request, occ_hit,
        output occ_query, occ_addr, food_x, food_y, food_valid, busy, grid_full
    );
endinterface

// File: rtl/food_placer.sv
// Picks a free food cell from the PRBS value, checking occupancy against the snake body store.
// Random candidates are tried first; after MAX_TRIES rejections a raster scan guarantees termination.
module food_placer #(
    parameter int GRID_W    = 16,
    parameter int GRID_H    = 8,
    parameter int MAX_TRIES = 8
) (
    input  logic         clock_25,
    input  logic         reset,
    food_placer_if.slave bus
);
    localparam logic [2:0] IDLE       = 3'd0;
    localparam logic [2:0] SAMPLE     = 3'd1;
    localparam logic [2:0] ISSUE      = 3'd2;
    localparam logic [2:0] WAIT       = 3'd3;
    localparam logic [2:0] SCAN_ISSUE = 3'd4;
    localparam logic [2:0] SCAN_WAIT  = 3'd5;

    localparam logic [4:0] W_LIM    = 5'(GRID_W);
    localparam logic [3:0] H_LIM    = 4'(GRID_H);
    localparam logic [3:0] X_LAST   = 4'(GRID_W - 1);
    localparam logic [2:0] Y_LAST   = 3'(GRID_H - 1);
    localparam logic [7:0] TRY_LIM  = 8'(MAX_TRIES);
    localparam logic [7:0] CELL_CNT = 8'(GRID_W * GRID_H);

    logic [2:0] state;
    logic [7:0] tries;
    logic [7:0] scan_cnt;
    logic [3:0] cand_x;
    logic [2:0] cand_y;
    logic       scan_gap;
    logic       occ_query;
    logic [6:0] occ_addr;
    logic [3:0] food_x;
    logic [2:0] food_y;
    logic       food_valid;
    logic       busy;
    logic       grid_full;

    logic [3:0] rnd_x;
    logic [2:0] rnd_y;
    logic       rnd_ok;
    logic [7:0] tries_inc;
    logic [7:0] scan_inc;
    logic [3:0] next_x;
    logic [2:0] next_y;

    assign rnd_x     = bus.rnd[3:0];
    assign rnd_y     = bus.rnd[6:4];
    assign rnd_ok    = ({1'b0, rnd_x} < W_LIM) && ({1'b0, rnd_y} < H_LIM);
    assign tries_inc = (tries < TRY_LIM) ? tries + 8'd1 : tries;
    assign scan_inc  = (scan_cnt < CELL_CNT) ? scan_cnt + 8'd1 : scan_cnt;

    // Raster successor of the current candidate, wrapping the last cell back to (0,0).
    always_comb begin
        next_x = cand_x + 4'd1;
        next_y = cand_y;
        if (cand_x == X_LAST) begin
            next_x = 4'd0;
            next_y = (cand_y == Y_LAST) ? 3'd0 : cand_y + 3'd1;
        end
    end

    always_ff @(posedge clock_25) begin
        if (reset) begin
            state      <= IDLE;
            tries      <= 8'd0;
            scan_cnt   <= 8'd0;
            cand_x     <= 4'd0;
            cand_y     <= 3'd0;
            scan_gap   <= 1'b0;
            occ_query  <= 1'b0;
            occ_addr   <= 7'd0;
            food_x     <= 4'd0;
            food_y     <= 3'd0;
            food_valid <= 1'b0;
            busy       <= 1'b0;
            grid_full  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.food_request) begin
                        state      <= SAMPLE;
                        busy       <= 1'b1;
                        food_valid <= 1'b0;
                        grid_full  <= 1'b0;
                        tries      <= 8'd0;
                    end
                end
                SAMPLE: begin
                    if (!rnd_ok) begin
                        tries <= tries_inc;
                        if (tries_inc == TRY_LIM) begin
                            cand_x   <= 4'd0;
                            cand_y   <= 3'd0;
                            scan_cnt <= 8'd0;
                            state    <= SCAN_ISSUE;
                        end
                    end else begin
                        cand_x    <= rnd_x;
                        cand_y    <= rnd_y;
                        occ_addr  <= bus.rnd;
                        occ_query <= 1'b1;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    occ_query <= 1'b0;
                    state     <= WAIT;
                end
                WAIT: begin
                    if (!bus.occ_hit) begin
                        food_x     <= cand_x;
                        food_y     <= cand_y;
                        food_valid <= 1'b1;
                        busy       <= 1'b0;
                        state      <= IDLE;
                    end else begin
                        tries <= tries_inc;
                        if (tries_inc == TRY_LIM) begin
                            cand_x   <= next_x;
                            cand_y   <= next_y;
                            scan_cnt <= 8'd0;
                            state    <= SCAN_ISSUE;
                        end else begin
                            state <= SAMPLE;
                        end
                    end
                end
                SCAN_ISSUE: begin
                    occ_addr  <= {cand_y, cand_x};
                    occ_query <= 1'b1;
                    scan_cnt  <= scan_inc;
                    scan_gap  <= 1'b1;
                    state     <= SCAN_WAIT;
                end
                SCAN_WAIT: begin
                    // First cycle here is the gap while the body store answers.
                    if (scan_gap) begin
                        occ_query <= 1'b0;
                        scan_gap  <= 1'b0;
                    end else if (!bus.occ_hit) begin
                        food_x     <= cand_x;
                        food_y     <= cand_y;
                        food_valid <= 1'b1;
                        busy       <= 1'b0;
                        state      <= IDLE;
                    end else if (scan_cnt == CELL_CNT) begin
                        grid_full <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end else begin
                        cand_x <= next_x;
                        cand_y <= next_y;
                        state  <= SCAN_ISSUE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.occ_query  = occ_query;
    assign bus.occ_addr   = occ_addr;
    assign bus.food_x     = food_x;
    assign bus.food_y     = food_y;
    assign bus.food_valid = food_valid;
    assign bus.busy       = busy;
    assign bus.grid_full  = grid_full;
endmodule

// File: tb/tb_food_placer.sv
// Scoreboard bench for food_placer: a default instance and a narrow (12-wide, 2-try) instance.
// Expected lookups and placements are queued when a request is driven and checked as the DUT produces them.
module tb_food_placer;
    typedef struct packed {
        logic       valid;
        logic       full;
        logic [3:0] x;
        logic [2:0] y;
    } result_t;

    logic clock_25 = 1'b0;
    logic reset;

    always #20 clock_25 = ~clock_25;

    food_placer_if ifa();
    food_placer_if ifb();

    food_placer #(.GRID_W(16), .GRID_H(8), .MAX_TRIES(8)) dut_a (
        .clock_25 (clock_25),
        .reset    (reset),
        .bus      (ifa)
    );

    food_placer #(.GRID_W(12), .GRID_H(8), .MAX_TRIES(2)) dut_b (
        .clock_25 (clock_25),
        .reset    (reset),
        .bus      (ifb)
    );

    logic       map_a [128];
    logic       map_b [128];
    logic       pend_a;
    logic       pend_b;
    logic       prev_busy_a;
    logic       prev_busy_b;
    logic [6:0] qry_qa [$];
    logic [6:0] qry_qb [$];
    result_t    res_qa [$];
    result_t    res_qb [$];
    logic [6:0] rnd_seq [$];
    int         checks = 0;
    int         failures = 0;
    int         lat;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    function automatic result_t mkRes(input logic v, input logic f, input logic [3:0] x, input logic [2:0] y);
        result_t r;
        r.valid = v;
        r.full  = f;
        r.x     = x;
        r.y     = y;
        return r;
    endfunction

    function automatic logic busyOf(input int which);
        return (which == 0) ? ifa.busy : ifb.busy;
    endfunction

    function automatic logic [2:0] acceptVec(input int which);
        if (which == 0) return {ifa.busy, ifa.food_valid, ifa.grid_full};
        return {ifb.busy, ifb.food_valid, ifb.grid_full};
    endfunction

    function automatic logic [17:0] outVec(input int which);
        if (which == 0)
            return {ifa.occ_query, ifa.occ_addr, ifa.food_x, ifa.food_y, ifa.food_valid, ifa.busy, ifa.grid_full};
        return {ifb.occ_query, ifb.occ_addr, ifb.food_x, ifb.food_y, ifb.food_valid, ifb.busy, ifb.grid_full};
    endfunction

    task automatic driveRnd(input int which, input logic [6:0] v);
        if (which == 0) ifa.rnd = v;
        else ifb.rnd = v;
    endtask

    task automatic driveReq(input int which, input logic v);
        if (which == 0) ifa.food_request = v;
        else ifb.food_request = v;
    endtask

    task automatic setMapAll(input int which, input logic v);
        for (int i = 0; i < 128; i++) begin
            if (which == 0) map_a[i] = v;
            else map_b[i] = v;
        end
    endtask

    task automatic setCell(input int which, input logic [6:0] addr, input logic v);
        if (which == 0) map_a[addr] = v;
        else map_b[addr] = v;
    endtask

    task automatic pushQuery(input int which, input logic [6:0] addr);
        if (which == 0) qry_qa.push_back(addr);
        else qry_qb.push_back(addr);
    endtask

    // Stuck-at-zero PRBS on the default grid: eight random hits on cell 0, then a full scan from cell 1.
    task automatic pushStuckZeroScan();
        for (int i = 0; i < 8; i++) pushQuery(0, 7'h00);
        for (int i = 1; i < 128; i++) pushQuery(0, 7'(i));
        pushQuery(0, 7'h00);
    endtask

    // Pulses a request, plays rnd_seq one value per edge (last value held) and waits for busy to drop.
    task automatic applyStimulus(input int which, input int budget, input int abort_at, output int latency);
        int n;
        int k;
        @(negedge clock_25);
        driveRnd(which, rnd_seq[0]);
        driveReq(which, 1'b1);
        n = 0;
        k = 1;
        while (n < budget) begin
            @(negedge clock_25);
            n++;
            if (n == 1) begin
                driveReq(which, 1'b0);
                checkOutput($sformatf("accept%0d", which), 32'(acceptVec(which)), 32'(3'b100));
            end else if (k < rnd_seq.size()) begin
                driveRnd(which, rnd_seq[k]);
                k++;
            end
            if (n == abort_at) reset = 1'b1;
            if (!busyOf(which)) break;
        end
        if (abort_at > 0) begin
            reset = 1'b0;
            checkOutput($sformatf("abort_zero%0d", which), 32'(outVec(which)), 32'd0);
            if (which == 0) qry_qa.delete();
            else qry_qb.delete();
        end
        if (busyOf(which)) checkOutput($sformatf("done_timeout%0d", which), 32'(busyOf(which)), 32'd0);
        latency = n - 1;
    endtask

    // Body-store model (answer one cycle after the query) plus lookup and placement monitors.
    always @(negedge clock_25) begin
        result_t r;
        logic [6:0] q;
        ifa.occ_hit = pend_a;
        pend_a = (ifa.occ_query === 1'b1) && map_a[ifa.occ_addr];
        ifb.occ_hit = pend_b;
        pend_b = (ifb.occ_query === 1'b1) && map_b[ifb.occ_addr];

        if (ifa.occ_query === 1'b1) begin
            if (qry_qa.size() > 0) begin
                q = qry_qa.pop_front();
                checkOutput("query_addr_a", 32'(ifa.occ_addr), 32'(q));
            end else begin
                checkOutput("query_extra_a", 32'(ifa.occ_query), 32'd0);
            end
        end
        if (ifb.occ_query === 1'b1) begin
            if (qry_qb.size() > 0) begin
                q = qry_qb.pop_front();
                checkOutput("query_addr_b", 32'(ifb.occ_addr), 32'(q));
            end else begin
                checkOutput("query_extra_b", 32'(ifb.occ_query), 32'd0);
            end
        end

        if (prev_busy_a === 1'b1 && ifa.busy === 1'b0) begin
            if (res_qa.size() > 0) begin
                r = res_qa.pop_front();
                checkOutput("result_a", 32'({ifa.food_valid, ifa.grid_full, ifa.food_x, ifa.food_y}), 32'(r));
            end else begin
                checkOutput("result_extra_a", 32'(res_qa.size()), 32'd1);
            end
        end
        if (prev_busy_b === 1'b1 && ifb.busy === 1'b0) begin
            if (res_qb.size() > 0) begin
                r = res_qb.pop_front();
                checkOutput("result_b", 32'({ifb.food_valid, ifb.grid_full, ifb.food_x, ifb.food_y}), 32'(r));
            end else begin
                checkOutput("result_extra_b", 32'(res_qb.size()), 32'd1);
            end
        end
        prev_busy_a = ifa.busy;
        prev_busy_b = ifb.busy;
    end

    initial begin
        pend_a = 1'b0;
        pend_b = 1'b0;
        setMapAll(0, 1'b0);
        setMapAll(1, 1'b0);
        reset = 1'b1;
        driveRnd(0, 7'h00);
        driveRnd(1, 7'h00);
        driveReq(0, 1'b1);
        driveReq(1, 1'b1);

        // Reset held two cycles with a request pending: reset wins.
        repeat (2) @(negedge clock_25);
        checkOutput("reset_a", 32'(outVec(0)), 32'd0);
        checkOutput("reset_b", 32'(outVec(1)), 32'd0);
        reset = 1'b0;
        driveReq(0, 1'b0);
        driveReq(1, 1'b0);
        @(negedge clock_25);
        checkOutput("idle_after_reset_a", 32'(outVec(0)), 32'd0);
        checkOutput("idle_after_reset_b", 32'(outVec(1)), 32'd0);

        // Best case on the default grid.
        setMapAll(0, 1'b0);
        rnd_seq = '{7'h25};
        pushQuery(0, 7'h25);
        res_qa.push_back(mkRes(1'b1, 1'b0, 4'd5, 3'd2));
        applyStimulus(0, 50, 0, lat);
        checkOutput("lat_best", 32'(lat), 32'd3);

        // Off-grid x on the 12-wide grid is rejected without a lookup.
        setMapAll(1, 1'b0);
        rnd_seq = '{7'h0E, 7'h13};
        pushQuery(1, 7'h13);
        res_qb.push_back(mkRes(1'b1, 1'b0, 4'd3, 3'd1));
        applyStimulus(1, 50, 0, lat);
        checkOutput("lat_offgrid", 32'(lat), 32'd4);

        // Two random hits, then the scan continues from the rejected cell.
        setMapAll(1, 1'b1);
        setCell(1, 7'h27, 1'b0);
        rnd_seq = '{7'h25};
        pushQuery(1, 7'h25);
        pushQuery(1, 7'h25);
        pushQuery(1, 7'h26);
        pushQuery(1, 7'h27);
        res_qb.push_back(mkRes(1'b1, 1'b0, 4'd7, 3'd2));
        applyStimulus(1, 80, 0, lat);
        checkOutput("lat_scan", 32'(lat), 32'd12);

        // Scan from the last cell wraps to (0,0).
        setMapAll(1, 1'b1);
        setCell(1, 7'h00, 1'b0);
        rnd_seq = '{7'h7B};
        pushQuery(1, 7'h7B);
        pushQuery(1, 7'h7B);
        pushQuery(1, 7'h00);
        res_qb.push_back(mkRes(1'b1, 1'b0, 4'd0, 3'd0));
        applyStimulus(1, 80, 0, lat);
        checkOutput("lat_wrap", 32'(lat), 32'd9);

        // Scan from the last column moves to the next row.
        setMapAll(1, 1'b1);
        setCell(1, 7'h20, 1'b0);
        rnd_seq = '{7'h1B};
        pushQuery(1, 7'h1B);
        pushQuery(1, 7'h1B);
        pushQuery(1, 7'h20);
        res_qb.push_back(mkRes(1'b1, 1'b0, 4'd0, 3'd2));
        applyStimulus(1, 80, 0, lat);
        checkOutput("lat_rowstep", 32'(lat), 32'd9);

        // Only off-grid randoms: fallback scan starts at (0,0).
        setMapAll(1, 1'b1);
        setCell(1, 7'h02, 1'b0);
        rnd_seq = '{7'h0F};
        pushQuery(1, 7'h00);
        pushQuery(1, 7'h01);
        pushQuery(1, 7'h02);
        res_qb.push_back(mkRes(1'b1, 1'b0, 4'd2, 3'd0));
        applyStimulus(1, 80, 0, lat);
        checkOutput("lat_fallback", 32'(lat), 32'd11);

        // First random cell occupied, second free.
        setMapAll(0, 1'b0);
        setCell(0, 7'h25, 1'b1);
        rnd_seq = '{7'h25, 7'h25, 7'h25, 7'h40};
        pushQuery(0, 7'h25);
        pushQuery(0, 7'h40);
        res_qa.push_back(mkRes(1'b1, 1'b0, 4'd0, 3'd4));
        applyStimulus(0, 80, 0, lat);
        checkOutput("lat_retry", 32'(lat), 32'd6);

        // Every cell occupied with a stuck PRBS: grid_full after 128 scan lookups, last food kept.
        setMapAll(0, 1'b1);
        rnd_seq = '{7'h00};
        pushStuckZeroScan();
        res_qa.push_back(mkRes(1'b0, 1'b1, 4'd0, 3'd4));
        applyStimulus(0, 1000, 0, lat);
        checkOutput("lat_full", 32'(lat), 32'd408);

        // New request clears grid_full; reset mid-scan aborts with everything cleared.
        pushStuckZeroScan();
        res_qa.push_back(mkRes(1'b0, 1'b0, 4'd0, 3'd0));
        applyStimulus(0, 1000, 30, lat);

        @(negedge clock_25);
        checkOutput("qry_left_a", 32'(qry_qa.size()), 32'd0);
        checkOutput("qry_left_b", 32'(qry_qb.size()), 32'd0);
        checkOutput("res_left_a", 32'(res_qa.size()), 32'd0);
        checkOutput("res_left_b", 32'(res_qb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/food_placer.md
Name: food_placer

Overview:
- Downstream consumer of the 7-bit PRBS value; turns it into the next food cell on the snake playfield.
- On a food request (game start, or the snake eats), it samples the random value and splits it into x/y.
- It rejects candidates that are off-grid or occupied by the snake, and returns a free cell.
- After MAX_TRIES random rejections it falls back to a deterministic raster scan, so placement always terminates.

Parameters:
- GRID_W, 16, playfield width in cells (1..16); x = rnd[3:0].
- GRID_H, 8, playfield height in cells (1..8); y = rnd[6:4].
- MAX_TRIES, 8, random rejections allowed before the scan fallback (1..255).

Ports:
- clock_25  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- rnd  in  7  PRBS output; advances every clock.
- food_request  in  1  one-cycle pulse requesting a new food position.
- occ_hit  in  1  occupancy answer from snake body store; valid the cycle after occ_query.
- occ_query  out  1  one-cycle strobe for an occupancy lookup.
- occ_addr  out  7  lookup cell, {y[2:0], x[3:0]}.
- food_x  out  4  food column.
- food_y  out  3  food row.
- food_valid  out  1  high while food_x/food_y hold a placed food.
- busy  out  1  high while a placement is in progress.
- grid_full  out  1  sticky; no free cell was found.

Behaviour:
- All outputs and state are registered.
- Reset values: state=IDLE, food_x=0, food_y=0, food_valid=0, busy=0, grid_full=0, occ_query=0, occ_addr=0, tries=0, scan_cnt=0.
- Reset is sampled every edge and overrides everything:
  - reset mid-placement aborts the placement with no partial output update;
  - reset and food_request in the same cycle: reset wins.
- States: IDLE, SAMPLE, ISSUE, WAIT, SCAN_ISSUE, SCAN_WAIT.
- IDLE:
  - food_request=1 -> SAMPLE; set busy=1, food_valid=0, grid_full=0, tries=0.
  - food_request while busy is ignored.
- SAMPLE (one edge per attempt): cand_x=rnd[3:0], cand_y=rnd[6:4].
  - If cand_x>=GRID_W or cand_y>=GRID_H: tries+1; stay SAMPLE (uses the next rnd).
  - If tries reaches MAX_TRIES: go to SCAN_ISSUE with cand=(0,0).
  - Otherwise (in range): occ_addr={cand_y,cand_x}, occ_query=1, -> ISSUE.
- ISSUE: occ_query=0, -> WAIT (occ_hit is valid during this cycle's successor).
- WAIT: sample occ_hit.
  - occ_hit=0: food_x/food_y=cand, food_valid=1, busy=0, -> IDLE.
  - occ_hit=1: tries+1. If tries==MAX_TRIES, advance cand one raster step, scan_cnt=0, -> SCAN_ISSUE; else -> SAMPLE.
- Best-case latency: request sampled at edge E0 -> rnd captured at E1 -> occ_query high E1..E2 -> occ_hit valid E2..E3 -> food_valid=1 after E3 (3 clocks).
- Raster step: x+1; at x==GRID_W-1, x=0 and y+1; at y==GRID_H-1 with x==GRID_W-1, wrap to (0,0).
- SCAN_ISSUE: occ_addr=cand, occ_query=1, scan_cnt+1, -> SCAN_WAIT. Each scanned cell costs 3 clocks (issue, gap, sample).
- SCAN_WAIT: sample occ_hit.
  - occ_hit=0: place food as in WAIT.
  - occ_hit=1 and scan_cnt==GRID_W*GRID_H: grid_full=1, busy=0, food_valid stays 0, -> IDLE.
  - Otherwise: advance cand, -> SCAN_ISSUE.
- food_valid stays high, and food_x/food_y are stable, until the next accepted food_request; food_valid drops at that edge.
- An all-zero rnd (PRBS stuck) is handled like any other value; the scan fallback guarantees termination.
- tries and scan_cnt saturate at their limits and never wrap.

Test Plan:
1. Assert reset 2 cycles with food_request=1 -> all outputs 0; no occ_query pulse.
2. Default params, rnd=7'h25, occ_hit=0, pulse request -> occ_query one cycle with occ_addr=7'h25; food_x=5, food_y=2, food_valid=1 exactly 3 clocks after the request edge; busy high for those 3 clocks.
3. GRID_W=12, rnd=7'h0E then 7'h13, occ_hit=0 -> 7'h0E rejected without query; occ_addr=7'h13; food=(3,1).
4. rnd=7'h25 then 7'h40; occ_hit=1 for the first query, 0 for the second -> food=(0,4); food_valid low until the second WAIT.
5. MAX_TRIES=2, occ_hit=1 for all queries except cell 7'h27 -> after 2 rejections of 7'h25, scan visits 7'h26 then 7'h27; food=(7,2).
6. occ_hit always 1 -> grid_full=1 and busy=0 after 128 scan lookups; a new request clears grid_full. Separately, reset mid-scan -> all outputs return to 0 on the next edge.
